// File: rtl/alu_pkg.sv
// Purpose: shared ALU control codes, widths and the buffered result-entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;

    // One buffered execute result: flags travel with the data they describe.
    typedef struct packed {
        logic              illegal;
        logic              overflow;
        logic              carry;
        logic              negative;
        logic              zero;
        logic [DATA_W-1:0] result;
    } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational AND/OR/ADD/SUB with zero/negative/carry/overflow/illegal flags.
// Latency: zero cycles (pure combinational).
// Backpressure: none; evaluates whatever is on its inputs.
// Ports: alu_control (op code), op_a/op_b (operands), res (packed result entry).
module alu_core
    import alu_pkg::*;
(
    input  logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output alu_entry_t        res
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    // Carry-out of a + ~b + 1 is the unsigned no-borrow (a >= b) indicator.
    assign diff = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        res = '0;
        case (alu_control)
            ALU_AND: res.result = op_a & op_b;
            ALU_OR:  res.result = op_a | op_b;
            ALU_ADD: begin
                res.result   = sum[DATA_W-1:0];
                res.carry    = sum[DATA_W];
                res.overflow = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            ALU_SUB: begin
                res.result   = diff[DATA_W-1:0];
                res.carry    = diff[DATA_W];
                res.overflow = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            // Undefined codes still flow down the pipe as a zero result so the
            // later stages see a well-defined value alongside the illegal flag.
            default: res.illegal = 1'b1;
        endcase
        res.zero     = (res.result == '0);
        res.negative = res.result[MSB];
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Purpose: registered ALU execute stage with a 2-entry result buffer.
// Latency: op accepted at edge N is at the outputs from edge N (out_valid in cycle N+1).
// Backpressure: in_ready drops when both entries are full; depends only on buffer count.
// Ports: clk/rst_n/flush control; in_valid/in_ready + alu_control/op_a/op_b upstream;
//        out_valid/out_ready + result/zero/negative/carry/overflow/illegal downstream.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow,
    output logic              illegal
);

    alu_entry_t core_res;
    alu_entry_t mem [2];
    alu_entry_t head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    alu_core u_core (
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .res         (core_res)
    );

    // Ready comes straight from the count register, so a downstream stall
    // never ripples combinationally back into the ID/EX stage.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);

    // Flush overrides any handshake in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= core_res;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Empty buffer presents an all-zero head rather than a stale entry.
    assign head = (count == 2'd0) ? '0 : mem[rd_ptr];

    assign result   = head.result;
    assign zero     = head.zero;
    assign negative = head.negative;
    assign carry    = head.carry;
    assign overflow = head.overflow;
    assign illegal  = head.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              negative;
    logic              carry;
    logic              overflow;
    logic              illegal;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks a valid head entry and all of its flags.
    task automatic chk_head(input string tag, input logic [7:0] r, input logic z,
                            input logic n, input logic c, input logic v, input logic ill);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"},    32'(result),    32'(r));
        chk({tag, ".zero"},      32'(zero),      32'(z));
        chk({tag, ".negative"},  32'(negative),  32'(n));
        chk({tag, ".carry"},     32'(carry),     32'(c));
        chk({tag, ".overflow"},  32'(overflow),  32'(v));
        chk({tag, ".illegal"},   32'(illegal),   32'(ill));
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b);
        in_valid    = v;
        alu_control = ctl;
        op_a        = a;
        op_b        = b;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, ALU_AND, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result",    32'(result),    32'd0);
        chk("rst.flags",     32'({zero, negative, carry, overflow, illegal}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready",  32'(in_ready),  32'd1);

        // ADD signed overflow: 0x7F + 0x01
        out_ready = 1'b1;
        drive(1'b1, ALU_ADD, 8'h7F, 8'h01);
        cyc();
        chk_head("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // SUB equal, simultaneous push/pop keeps the stream bubble-free
        drive(1'b1, ALU_SUB, 8'h35, 8'h35);
        cyc();
        chk_head("sub_eq", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, ALU_SUB, 8'h00, 8'h01);
        cyc();
        chk_head("sub_borrow", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        cyc();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Backpressure: fill both entries, third op waits
        out_ready = 1'b0;
        drive(1'b1, ALU_AND, 8'hF0, 8'h3C);
        cyc();
        drive(1'b1, ALU_OR, 8'hF0, 8'h0F);
        cyc();
        chk("bp.in_ready_full", 32'(in_ready), 32'd0);
        drive(1'b1, ALU_ADD, 8'h05, 8'h06);
        cyc();
        chk("bp.in_ready_held", 32'(in_ready), 32'd0);
        chk_head("bp.first_held", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk_head("bp.second", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp.in_ready_after_pop", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        chk_head("bp.third", 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("bp.drained", 32'(out_valid), 32'd0);

        // Streaming: 8 back-to-back ADDs, a=i, b=2i
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ALU_ADD, 8'(i), 8'(2 * i));
            cyc();
            chk($sformatf("stream%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d.result", i),    32'(result),    32'(3 * i));
            chk($sformatf("stream%0d.in_ready", i),  32'(in_ready),  32'd1);
        end
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        cyc();
        chk("stream.drained", 32'(out_valid), 32'd0);

        // Illegal code flows through, next legal op clears illegal
        drive(1'b1, 4'b1111, 8'h12, 8'h34);
        cyc();
        chk_head("illegal", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, ALU_OR, 8'h01, 8'h02);
        cyc();
        chk_head("legal_after", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        cyc();

        // Flush with two buffered ops and an incoming op
        out_ready = 1'b0;
        drive(1'b1, ALU_ADD, 8'h01, 8'h01);
        cyc();
        drive(1'b1, ALU_ADD, 8'h02, 8'h02);
        cyc();
        chk("flush.full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, ALU_ADD, 8'h09, 8'h09);
        cyc();
        flush = 1'b0;
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready",  32'(in_ready),  32'd1);
        chk("flush.result",    32'(result),    32'd0);

        // Flush at count 1 with a simultaneous push: the push is dropped
        drive(1'b1, ALU_ADD, 8'h10, 8'h10);
        cyc();
        flush = 1'b1;
        drive(1'b1, ALU_ADD, 8'h11, 8'h11);
        cyc();
        flush = 1'b0;
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        chk("flush_push.out_valid", 32'(out_valid), 32'd0);

        // Buffer usable after flush
        drive(1'b1, ALU_ADD, 8'h03, 8'h04);
        cyc();
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        chk_head("post_flush", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle with two buffered ops
        drive(1'b1, ALU_ADD, 8'h20, 8'h01);
        cyc();
        drive(1'b1, ALU_ADD, 8'h30, 8'h01);
        cyc();
        drive(1'b0, ALU_AND, 8'h00, 8'h00);
        chk("arst.pre_valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.result",    32'(result),    32'd0);
        chk("arst.in_ready",  32'(in_ready),  32'd1);
        #2;
        rst_n = 1'b1;
        cyc();
        chk("arst.after_edge", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage of the 8-bit RISC-V pipeline.
- Consumes the 4-bit ALU control code and two 8-bit operands, then computes AND/OR/ADD/SUB and the condition flags.
- Results are held in a 2-entry result buffer with valid/ready handshakes on both sides, so MEM-stage stalls never corrupt an in-flight result.
- Sits between the ID/EX operand latch (upstream) and the EX/MEM consumer (downstream); pipeline flush is supported.

Parameters:
- DATA_W, 8, operand/result width in bits.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards buffered and incoming ops.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  stage can accept an op this cycle.
- alu_control  input  CTRL_W  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- op_a  input  DATA_W  operand A.
- op_b  input  DATA_W  operand B.
- out_valid  output  1  head result valid.
- out_ready  input  1  downstream accepts head result.
- result  output  DATA_W  head result.
- zero  output  1  result == 0 (used for beq).
- negative  output  1  result[DATA_W-1].
- carry  output  1  ADD carry-out / SUB no-borrow (A >= B unsigned).
- overflow  output  1  signed overflow for ADD/SUB; 0 for logic ops.
- illegal  output  1  head op carried an undefined control code.

Behaviour:
- Reset (rst_n low, asynchronous): buffer count = 0. out_valid = 0, in_ready = 1 after release. result, zero, negative, carry, overflow and illegal all read 0.
- Accept when in_valid && in_ready at a rising edge. Pop when out_valid && out_ready.
- Arithmetic is computed combinationally at input and stored with flags into the tail entry:
  - AND: a & b.
  - OR: a | b.
  - ADD: {carry, result} = a + b (DATA_W+1 bit sum); overflow = (a[7] == b[7]) && (result[7] != a[7]).
  - SUB: {carry, result} = a + ~b + 1; overflow = (a[7] != b[7]) && (result[7] != a[7]).
  - Logic ops: carry = 0, overflow = 0.
  - Any other code: result = 0, carry = 0, overflow = 0, zero = 1, illegal = 1. The op still flows, with no stall or drop.
- Latency: op accepted at edge N appears at the outputs from edge N (out_valid high in cycle N+1) when the buffer was empty.
- Buffer is a 2-entry FIFO; outputs are driven from the head entry registers with no combinational path from inputs to result/flags.
- in_ready = (count != 2). It is a registered function of count only, with no combinational dependence on out_ready.
- Throughput is 1 op/cycle while out_ready stays high (count oscillates 0..1).
- Simultaneous push and pop at count 1: count stays 1. The head becomes the new op; there is no bubble.
- At count 2 with a pop: in_ready is low that cycle, so no push; count goes to 1.
- Wrap-around: read/write pointers are 1 bit each and toggle on pop/push respectively.
- flush high at an edge:
  - count becomes 0 and both pointers become 0.
  - Any simultaneous push or pop is ignored (flush wins).
  - out_valid is low the next cycle.
- Outputs other than out_valid are don't-care while out_valid is 0, but the RTL drives the empty-buffer head as 0.
- Reset mid-operation: all buffered ops are lost immediately. No output handshake completes in that cycle.

Decomposition:
- Shared package alu_pkg holds:
  - localparams ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;
  - DATA_W default;
  - the packed result-entry layout {illegal, overflow, carry, negative, zero, result}.
- One sub-module: alu_core, purely combinational, taking (alu_control, op_a, op_b) and producing the result plus all flags. alu_exec_stage instantiates it and owns the FIFO, pointers and handshake.

Test Plan:
- ADD overflow: after reset, push ADD a=0x7F b=0x01 with out_ready=1 -> next cycle out_valid=1, result=0x80, negative=1, overflow=1, carry=0, zero=0.
- SUB equal: push SUB a=0x35 b=0x35 -> result=0x00, zero=1, carry=1, overflow=0. Then push SUB a=0x00 b=0x01 -> result=0xFF, carry=0, negative=1.
- Backpressure: with out_ready=0, push AND 0xF0&0x3C, then OR 0xF0|0x0F. After 2 accepts in_ready=0 and the third op is held. Raise out_ready -> outputs 0x30 then 0xFF in order, and the third op is accepted the cycle after the first pop.
- Streaming: 8 back-to-back ADDs (a=i, b=2i) with out_ready=1 -> 8 results 0,3,...,21 on 8 consecutive cycles with no bubbles, and in_ready held 1 throughout.
- Illegal code: push alu_control=4'b1111 a=0x12 b=0x34 -> result=0x00, illegal=1, zero=1; the next legal op shows illegal=0.
- Flush and reset: buffer 2 ops, assert flush with in_valid=1 -> next cycle out_valid=0, count 0, and the incoming op is dropped. Repeat with rst_n pulsed low mid-cycle -> out_valid falls asynchronously, before the next edge.
